uart_rx: RTL and testbench

8N1 UART receiver paired with the existing transmitter: same bit timing parameter, LSB-first framing, one clock domain. Samples the asynchronous `rxd` pin through a synchronizer, validates the start bit at mid-bit, shifts in 8 data bits, checks the stop bit, and presents each byte with a one-cycle strobe. Sits between the board RX pin and the core's MMIO/loader logic.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first, single clock domain.
//
// The asynchronous serial pin is brought in through a two-flop synchronizer.
// A falling edge on the synchronized line starts a frame. The start bit is
// confirmed at mid-bit, eight data bits are sampled at their centres, and the
// stop bit is checked at mid-bit. A good frame updates rdata and pulses
// rx_ready. A frame with a low stop bit pulses ferr instead. The receiver
// then waits for the line to return high, so a held-low line (break)
// reports exactly one ferr.
//
// Parameters
//   CLK_PER_HALF_BIT : clock cycles per half bit period (must be >= 4)
//
// Ports
//   clk      : system clock, rising edge
//   rstn     : asynchronous active-low reset
//   rxd      : serial input, idle high, asynchronous to clk
//   rdata    : last correctly received byte, held until the next good byte
//   rx_ready : one-cycle strobe, rdata updated this cycle
//   ferr     : one-cycle strobe, frame ended with stop bit = 0
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] rdata,
   output logic       rx_ready,
   output logic       ferr
);

   localparam int unsigned BIT_CNT_MAX = 2 * CLK_PER_HALF_BIT - 1;
   localparam int unsigned CNT_W       = $clog2(BIT_CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t HALF_LOAD = cnt_t'(CLK_PER_HALF_BIT);
   localparam cnt_t FULL_LOAD = cnt_t'(BIT_CNT_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic       sync1_q;
   logic       sync2_q;
   logic       prev_q;
   state_t     state_q;
   cnt_t       cnt_q;
   logic [2:0] bit_q;
   logic [7:0] shift_q;
   logic [7:0] rdata_q;
   logic       rdy_q;
   logic       ferr_q;

   logic rxd_s;
   logic fall_d;
   logic cnt_zero_d;

   assign rxd_s      = sync2_q;
   assign fall_d     = prev_q & ~sync2_q;
   assign cnt_zero_d = (cnt_q == '0);

   // The falling edge is seen one cycle before the reference edge of the frame;
   // loading HALF_LOAD (instead of HALF_LOAD-1) absorbs that cycle so the start
   // check lands H edges after the reference edge and every later sample
   // follows 2H edges apart from there.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         rdata_q <= '0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (fall_d) begin
                  cnt_q   <= HALF_LOAD;
                  state_q <= S_START;
               end
            end

            S_START: begin
               if (cnt_zero_d) begin
                  if (!rxd_s) begin
                     cnt_q   <= FULL_LOAD;
                     bit_q   <= '0;
                     state_q <= S_DATA;
                  end else begin
                     // Line went back high before mid start bit: glitch.
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - cnt_t'(1);
               end
            end

            S_DATA: begin
               if (cnt_zero_d) begin
                  shift_q <= {rxd_s, shift_q[7:1]};
                  cnt_q   <= FULL_LOAD;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - cnt_t'(1);
               end
            end

            S_STOP: begin
               if (cnt_zero_d) begin
                  if (rxd_s) begin
                     rdata_q <= shift_q;
                     rdy_q   <= 1'b1;
                     // Re-arm at mid stop bit so a start bit right after a
                     // full-width stop bit is not missed.
                     state_q <= S_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q - cnt_t'(1);
               end
            end

            S_BREAK: begin
               if (rxd_s) begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rdata    = rdata_q;
   assign rx_ready = rdy_q;
   assign ferr     = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx with CLK_PER_HALF_BIT = 8.
//
// A line driver turns bytes into 8N1 waveforms with a selectable bit period
// (in thousandths of a cycle, so +/-3% rates are possible). A monitor records
// every strobe with its cycle number. The reference model predicts, per frame,
// the cycle and kind of the strobe and the rdata value at that moment.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int H      = 8;
   localparam int NOM_PM = 2 * H * 1000;   // nominal bit period, milli-cycles

   logic       clk;
   logic       rstn;
   logic       rxd;
   logic [7:0] rdata;
   logic       rx_ready;
   logic       ferr;

   uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rxd      (rxd),
      .rdata    (rdata),
      .rx_ready (rx_ready),
      .ferr     (ferr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         is_rdy;
      logic [7:0] data;
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   excl_viol = 0;
   logic prev_strobe = 1'b0;
   logic [7:0] last_good = 8'h00;

   // Strobe monitor: records events, flags overlap or multi-cycle strobes.
   always @(negedge clk) begin
      if (rstn && (rx_ready || ferr)) begin
         ev_t e;
         if ((rx_ready && ferr) || prev_strobe) excl_viol = excl_viol + 1;
         e.cyc    = cyc;
         e.is_rdy = rx_ready ? 1 : 0;
         e.data   = rdata;
         obs_q.push_back(e);
      end
      prev_strobe = rstn && (rx_ready || ferr);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Model of one frame: the strobe is registered 19 half bits after the
   // reference edge, which is 3 edges after the pin is first sampled low.
   task automatic expect_frame(input int e0, input logic [7:0] b, input logic stop);
      ev_t e;
      e.cyc = e0 + 3 + 19 * H;
      if (stop) begin
         e.is_rdy  = 1;
         e.data    = b;
         last_good = b;
      end else begin
         e.is_rdy = 0;
         e.data   = last_good;
      end
      exp_q.push_back(e);
   endtask

   // Drive one frame; must be called right after a falling clock edge.
   // cut > 0 abandons the frame after that many cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int pm,
                             input int cut, output int e0);
      logic [9:0] lv;
      int t;
      int bound;
      lv = {stop, b, 1'b0};
      t  = 0;
      e0 = cyc + 1;
      for (int k = 0; k < 10; k++) begin
         bound = ((k + 1) * pm + 500) / 1000;
         rxd = lv[k];
         while (t < bound) begin
            if (cut > 0 && t >= cut) return;
            @(negedge clk);
            t++;
         end
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic compare_events(input string ph);
      int n;
      check({ph, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({ph, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
         check({ph, "_kind"},  obs_q[i].is_rdy, exp_q[i].is_rdy);
         check({ph, "_rdata"}, obs_q[i].data, exp_q[i].data);
      end
      check({ph, "_strobe_excl"}, excl_viol, 0);
      obs_q.delete();
      exp_q.delete();
   endtask

   typedef struct {
      logic [7:0] b;
      logic       stop;
      int         pm;
      int         gap;
      int         exp_rdy;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      int d;
      ev_t e;

      tbl[0] = '{8'h55, 1'b1, NOM_PM,         20, 1, 8'h55};
      tbl[1] = '{8'hA3, 1'b1, NOM_PM,          0, 1, 8'hA3};
      tbl[2] = '{8'h0F, 1'b1, NOM_PM,         20, 1, 8'h0F};
      tbl[3] = '{8'hFF, 1'b1, NOM_PM * 103 / 100, 0, 1, 8'hFF};
      tbl[4] = '{8'h00, 1'b1, NOM_PM * 103 / 100, 20, 1, 8'h00};
      tbl[5] = '{8'hFF, 1'b1, NOM_PM * 97 / 100,  0, 1, 8'hFF};
      tbl[6] = '{8'h00, 1'b1, NOM_PM * 97 / 100, 20, 1, 8'h00};
      tbl[7] = '{8'h99, 1'b0, NOM_PM,         30, 0, 8'h00};

      // Reset state
      rxd  = 1'b1;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdata", rdata, 8'h00);
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_ferr", ferr, 1'b0);
      rstn = 1'b1;
      idle(20);
      check("post_rst_no_event", obs_q.size(), 0);

      // Table vectors: nominal, back-to-back, +/-3% rate, framing error
      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].b, tbl[i].stop, tbl[i].pm, 0, e0);
         e.cyc    = e0 + 3 + 19 * H;
         e.is_rdy = tbl[i].exp_rdy;
         e.data   = tbl[i].exp_data;
         exp_q.push_back(e);
         idle(tbl[i].gap);
      end
      last_good = 8'h00;
      idle(30);
      check("b2b_have_two", (obs_q.size() >= 3) ? 1 : 0, 1);
      if (obs_q.size() >= 3) begin
         d = obs_q[2].cyc - obs_q[1].cyc;
         check("b2b_spacing", d, 160);
      end
      check("first_strobe_E152", (obs_q.size() >= 1) ? obs_q[0].cyc : -1, exp_q[0].cyc);
      compare_events("table");

      // Glitch shorter than half a bit, then a real byte
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      check("glitch_no_event", obs_q.size(), 0);
      send_frame(8'h3C, 1'b1, NOM_PM, 0, e0);
      expect_frame(e0, 8'h3C, 1'b1);
      idle(30);
      compare_events("glitch");

      // Break: low stop bit, line held low 400 cycles, then a good byte
      send_frame(8'h81, 1'b0, NOM_PM, 0, e0);
      expect_frame(e0, 8'h81, 1'b0);
      repeat (200) @(negedge clk);
      check("break_rdata_hold", rdata, 8'h3C);
      repeat (184) @(negedge clk);
      check("break_one_ferr", obs_q.size(), 1);
      idle(40);
      send_frame(8'h7E, 1'b1, NOM_PM, 0, e0);
      expect_frame(e0, 8'h7E, 1'b1);
      idle(30);
      compare_events("break");

      // Reset in the middle of data bit 4
      send_frame(8'h5A, 1'b1, NOM_PM, 88, e0);
      rstn = 1'b0;
      #1;
      check("midrst_rdata", rdata, 8'h00);
      check("midrst_rx_ready", rx_ready, 1'b0);
      check("midrst_ferr", ferr, 1'b0);
      last_good = 8'h00;
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      rstn = 1'b1;
      idle(40);
      check("midrst_rdata_after", rdata, 8'h00);
      send_frame(8'hC6, 1'b1, NOM_PM, 0, e0);
      expect_frame(e0, 8'hC6, 1'b1);
      idle(30);
      compare_events("midrst");

      // Randomized frames against the model
      for (int i = 0; i < 16; i++) begin
         logic [7:0] b;
         logic       stop;
         int         pm;
         int         gap;
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 5) != 0);
         pm   = $urandom_range(NOM_PM * 97 / 100, NOM_PM * 103 / 100);
         gap  = stop ? $urandom_range(0, 12) : $urandom_range(8, 30);
         send_frame(b, stop, pm, 0, e0);
         expect_frame(e0, b, stop);
         idle(gap);
      end
      idle(30);
      compare_events("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
